// File: rtl/axi_ram_slave.sv
// AXI3 slave backed by a 2^ADDR_WIDTH x 32 RAM: one read burst and one write
// burst in flight at once, each channel with independent backpressure.
module axi_ram_slave #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic        aclk,
    input  logic        reset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

    function automatic logic [31:0] f_next_addr(input logic [31:0] a, input logic [3:0] len,
                                                input logic [1:0] burst);
        logic [31:0] mask;
        mask = {26'd0, len, 2'b00};
        case (burst)
            2'b00:   f_next_addr = a;
            2'b10:   f_next_addr = (a & ~mask) | ((a + 32'd4) & mask);
            default: f_next_addr = a + 32'd4;
        endcase
    endfunction

    function automatic logic f_bad(input logic [2:0] size, input logic [1:0] burst,
                                   input logic [3:0] len);
        f_bad = (size != 3'b010) || (burst == 2'b11) ||
                ((burst == 2'b10) && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15));
    endfunction

    logic [31:0] r_mem [0:DEPTH-1];

    rstate_t     r_rstate, w_rnext;
    logic [3:0]  r_rid, r_rcnt, r_rlen;
    logic [31:0] r_raddr, r_rdq;
    logic [1:0]  r_rburst;
    logic        r_rerr;
    logic        w_rd_en, w_rdec;

    wstate_t     w_wnext, r_wstate;
    logic [3:0]  r_bid, r_wcnt, r_wlen;
    logic [31:0] r_waddr;
    logic [1:0]  r_wburst, r_bresp;
    logic        r_werr, r_wover;
    logic        w_whs, w_we;

    logic [ADDR_WIDTH-1:0] w_ridx, w_widx;
    logic                  w_unused;

    assign w_ridx   = r_raddr[ADDR_WIDTH+1:2];
    assign w_widx   = r_waddr[ADDR_WIDTH+1:2];
    assign w_unused = &{1'b0, arlock, arcache, arprot, awlock, awcache, awprot, wid};

    // ---------------- read channel ----------------
    always_ff @(posedge aclk) begin
        if (reset) r_rstate <= R_IDLE;
        else       r_rstate <= w_rnext;
    end

    always_comb begin
        w_rnext = r_rstate;
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        w_rd_en = 1'b0;
        w_rdec  = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) w_rnext = R_FETCH;
            end
            R_FETCH: begin
                w_rd_en = 1'b1;
                w_rnext = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                rlast  = (r_rcnt == 4'd0);
                if (rready) begin
                    if (r_rcnt == 4'd0) begin
                        w_rnext = R_IDLE;
                    end else begin
                        w_rd_en = 1'b1;
                        w_rdec  = 1'b1;
                    end
                end
            end
            default: w_rnext = R_IDLE;
        endcase
    end

    // The output register only loads on a fetch, so stalled beats stay stable.
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_rid    <= '0;
            r_raddr  <= '0;
            r_rcnt   <= '0;
            r_rlen   <= '0;
            r_rburst <= '0;
            r_rerr   <= 1'b0;
            r_rdq    <= '0;
        end else begin
            if (arvalid && arready) begin
                r_rid    <= arid;
                r_raddr  <= araddr;
                r_rcnt   <= arlen;
                r_rlen   <= arlen;
                r_rburst <= arburst;
                r_rerr   <= f_bad(arsize, arburst, arlen);
            end
            if (w_rd_en) begin
                r_rdq   <= r_rerr ? 32'd0 : r_mem[w_ridx];
                r_raddr <= f_next_addr(r_raddr, r_rlen, r_rburst);
            end
            if (w_rdec) r_rcnt <= r_rcnt - 4'd1;
        end
    end

    assign rid   = r_rid;
    assign rdata = r_rdq;
    assign rresp = r_rerr ? SLVERR : 2'b00;

    // ---------------- write channel ----------------
    always_ff @(posedge aclk) begin
        if (reset) r_wstate <= W_IDLE;
        else       r_wstate <= w_wnext;
    end

    always_comb begin
        w_wnext = r_wstate;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) w_wnext = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && wlast) w_wnext = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_wnext = W_IDLE;
            end
            default: w_wnext = W_IDLE;
        endcase
    end

    assign w_whs = (r_wstate == W_DATA) && wvalid;
    assign w_we  = w_whs && !r_werr && !r_wover && !reset;

    // r_wover marks beats past awlen: dropped, and the burst reports SLVERR.
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_bid    <= '0;
            r_waddr  <= '0;
            r_wcnt   <= '0;
            r_wlen   <= '0;
            r_wburst <= '0;
            r_werr   <= 1'b0;
            r_wover  <= 1'b0;
            r_bresp  <= '0;
        end else begin
            if (awvalid && awready) begin
                r_bid    <= awid;
                r_waddr  <= awaddr;
                r_wcnt   <= awlen;
                r_wlen   <= awlen;
                r_wburst <= awburst;
                r_werr   <= f_bad(awsize, awburst, awlen);
                r_wover  <= 1'b0;
                r_bresp  <= f_bad(awsize, awburst, awlen) ? SLVERR : 2'b00;
            end
            if (w_whs) begin
                r_waddr <= f_next_addr(r_waddr, r_wlen, r_wburst);
                if (r_wcnt != 4'd0) begin
                    r_wcnt <= r_wcnt - 4'd1;
                    if (wlast) r_bresp <= SLVERR;
                end else if (!wlast) begin
                    r_wover <= 1'b1;
                    r_bresp <= SLVERR;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) r_mem[w_widx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign bid   = r_bid;
    assign bresp = r_bresp;

endmodule
